// File: rtl/line_fill_engine_if.sv
// Line fill engine bus bundle: cache request/response plus AXI read channels.
// master = engine side, slave = cache/memory side.
interface line_fill_engine_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BEATS      = 16
);
  localparam int LINE_W = DATA_WIDTH * BEATS;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [LINE_W-1:0]     resp_data;
  logic                  resp_error;

  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arlock;
  logic [3:0]            m_axi_arcache;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;

  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  req_valid, req_addr, resp_ready,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp,
    input  m_axi_rlast, m_axi_rvalid,
    output req_ready, resp_valid, resp_data, resp_error,
    output m_axi_arid, m_axi_araddr, m_axi_arlen,
    output m_axi_arsize, m_axi_arburst, m_axi_arlock,
    output m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    output m_axi_rready
  );

  modport slave (
    output req_valid, req_addr, resp_ready,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp,
    output m_axi_rlast, m_axi_rvalid,
    input  req_ready, resp_valid, resp_data, resp_error,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen,
    input  m_axi_arsize, m_axi_arburst, m_axi_arlock,
    input  m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/line_fill_engine.sv
// Cache line fill engine: one outstanding AXI INCR burst per line miss.
// Ports: clk, reset (sync, active-high), bus (line_fill_engine_if.master).
module line_fill_engine #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BEATS      = 16
) (
  input  logic                clk,
  input  logic                reset,
  line_fill_engine_if.master  bus
);
  localparam int LINE_W = DATA_WIDTH * BEATS;
  localparam int OFF    = $clog2(DATA_WIDTH / 8 * BEATS);
  localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_ADDR, S_DATA, S_RESP
  } state_t;

  state_t                r_state;
  logic                  r_req_ready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_resp_valid;
  logic                  r_resp_error;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CW-1:0]         r_cnt;
  logic [LINE_W-1:0]     r_line;

  logic w_beat;
  logic w_last;
  logic w_bad;
  logic w_unused;

  // rready is only ever high in DATA, so stray rvalid is dropped.
  assign w_beat = r_rready & bus.m_axi_rvalid;
  assign w_last = (r_cnt == LAST);
  // rlast must coincide exactly with the final counted beat.
  assign w_bad  = (bus.m_axi_rresp != 2'b00)
                | (bus.m_axi_rlast != w_last);

  assign w_unused = ^{bus.m_axi_rid, bus.req_addr[OFF-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_line       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr      <= {bus.req_addr[ADDR_WIDTH-1:OFF],
                            OFF'(0)};
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b0;
            r_arvalid   <= 1'b1;
            r_state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus.m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_line[r_cnt*DATA_WIDTH +: DATA_WIDTH]
              <= bus.m_axi_rdata;
            r_err <= r_err | w_bad;
            // Beat count alone ends the burst.
            if (w_last) begin
              r_rready     <= 1'b0;
              r_resp_valid <= 1'b1;
              r_resp_error <= r_err | w_bad;
              r_state      <= S_RESP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_RESP: begin
          // IDLE is re-entered before any new request is taken.
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = r_req_ready;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_error    = r_resp_error;
  assign bus.resp_data     = r_line;
  assign bus.m_axi_arid    = '0;
  assign bus.m_axi_araddr  = r_addr;
  assign bus.m_axi_arlen   = 8'(BEATS - 1);
  assign bus.m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = 4'b0011;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_rready  = r_rready;
endmodule

// File: tb/tb_line_fill_engine.sv
// Testbench for line_fill_engine: scenario tasks against a line-level model.
// Drives the interface slave side; samples on the falling edge.
module tb_line_fill_engine;
  localparam int IW = 13;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int NB = 16;
  localparam int LW = DW * NB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  line_fill_engine_if #(
    .ID_WIDTH(IW), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .BEATS(NB)
  ) bus ();

  line_fill_engine #(
    .ID_WIDTH(IW), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .BEATS(NB)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad = 0;

  logic [DW-1:0] tb_data [NB];
  logic [1:0]    tb_resp [NB];
  logic          tb_last [NB];

  logic [AW-1:0] o_araddr;
  logic [7:0]    o_arlen;
  logic [2:0]    o_arsize;
  logic [1:0]    o_arburst;
  logic [IW-1:0] o_arid;
  logic [3:0]    o_arcache;
  logic [2:0]    o_arprot;
  logic          o_arlock;
  logic [LW-1:0] o_data;
  logic          o_err;
  logic          o_accepted;
  logic          o_rdy_after;
  logic          o_arv_after;
  logic          o_timeout;
  int o_ar_hs, o_ar_unstable, o_latency, o_gaps;
  int o_resp_unstable, o_rready_bad, o_reqrdy_bad;
  int o_beats, o_resp_seen;

  // Reference model: line = beats concatenated, beat k at [64k+63:64k].
  function automatic logic [LW-1:0] model_line();
    logic [LW-1:0] l;
    for (int k = 0; k < NB; k++) l[k*DW +: DW] = tb_data[k];
    return l;
  endfunction

  // Error if any beat had a bad response or rlast is out of place.
  function automatic logic model_err();
    logic e = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (tb_resp[k] != 2'b00) e = 1'b1;
      if (tb_last[k] != (k == NB - 1)) e = 1'b1;
    end
    return e;
  endfunction

  task automatic set_beats(input bit rnd);
    for (int k = 0; k < NB; k++) begin
      tb_data[k] = rnd ? {$urandom, $urandom} : DW'(k);
      tb_resp[k] = 2'b00;
      tb_last[k] = (k == NB - 1);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid     = 1'b0;
    bus.req_addr      = '0;
    bus.resp_ready    = 1'b0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rid     = '0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = '0;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
  endtask

  // Slave-side driver: issues one request, plays the AXI memory and
  // records what the engine did. Comparisons live in the test tasks.
  task automatic run_fill(
    input logic [AW-1:0] addr,
    input int ar_wait,
    input bit gaps,
    input int resp_wait,
    input bit hold_req,
    input int abort_at
  );
    int cyc, arcnt, rwcnt;
    bit done, first_ar, first_resp, in_data, abort;
    o_ar_hs = 0; o_ar_unstable = 0; o_latency = -1;
    o_gaps = 0; o_resp_unstable = 0; o_rready_bad = 0;
    o_reqrdy_bad = 0; o_beats = 0; o_resp_seen = 0;
    o_data = '0; o_err = 1'b0;
    cyc = 0; arcnt = 0; rwcnt = 0; done = 0;
    first_ar = 1; first_resp = 1; abort = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    o_accepted    = bus.req_ready;
    @(posedge clk);
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (!hold_req) bus.req_valid = 1'b0;
      bus.m_axi_arready = 1'b0;
      bus.resp_ready    = 1'b0;
      bus.m_axi_rvalid  = 1'b0;
      if (bus.req_ready) o_reqrdy_bad++;
      in_data = (o_ar_hs > 0) && (o_beats < NB);
      if (bus.m_axi_arvalid) begin
        if (first_ar) begin
          first_ar  = 0;
          o_araddr  = bus.m_axi_araddr;
          o_arlen   = bus.m_axi_arlen;
          o_arsize  = bus.m_axi_arsize;
          o_arburst = bus.m_axi_arburst;
          o_arid    = bus.m_axi_arid;
          o_arcache = bus.m_axi_arcache;
          o_arprot  = bus.m_axi_arprot;
          o_arlock  = bus.m_axi_arlock;
        end else if (bus.m_axi_araddr !== o_araddr ||
                     bus.m_axi_arlen !== o_arlen) begin
          o_ar_unstable++;
        end
        if (arcnt >= ar_wait) begin
          bus.m_axi_arready = 1'b1;
          o_ar_hs++;
        end
        arcnt++;
      end
      bus.m_axi_rid = IW'($urandom);
      if (in_data) begin
        if (abort_at == o_beats) abort = 1;
        if (gaps && !abort && $urandom_range(0, 3) == 0) begin
          o_gaps++;
        end else begin
          bus.m_axi_rvalid = 1'b1;
          bus.m_axi_rdata  = tb_data[o_beats];
          bus.m_axi_rresp  = tb_resp[o_beats];
          bus.m_axi_rlast  = tb_last[o_beats];
          if (!bus.m_axi_rready) o_rready_bad++;
          else if (!abort) o_beats++;
        end
      end else begin
        // Junk on R outside the burst must be ignored.
        bus.m_axi_rvalid = 1'($urandom_range(0, 1));
        bus.m_axi_rdata  = {$urandom, $urandom};
        bus.m_axi_rresp  = 2'($urandom);
        bus.m_axi_rlast  = 1'($urandom);
        if (bus.m_axi_rready) o_rready_bad++;
      end
      if (bus.resp_valid) begin
        o_resp_seen++;
        if (first_resp) begin
          first_resp = 0;
          o_latency  = cyc - 1;
          o_data     = bus.resp_data;
          o_err      = bus.resp_error;
        end else if (bus.resp_data !== o_data ||
                     bus.resp_error !== o_err) begin
          o_resp_unstable++;
        end
        if (rwcnt >= resp_wait) begin
          bus.resp_ready = 1'b1;
          done = 1;
        end
        rwcnt++;
      end
      if (abort) begin
        reset = 1'b1;
        @(posedge clk);
        return;
      end
      @(posedge clk);
    end
    o_timeout = !done;
    @(negedge clk);
    o_rdy_after = bus.req_ready;
    o_arv_after = bus.m_axi_arvalid;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++;
      $display("FAIL rst_req_ready got=%b want=1", bus.req_ready); end
    total++; if (bus.m_axi_arvalid !== 1'b0) begin bad++;
      $display("FAIL rst_arvalid got=%b want=0", bus.m_axi_arvalid); end
    total++; if (bus.m_axi_rready !== 1'b0) begin bad++;
      $display("FAIL rst_rready got=%b want=0", bus.m_axi_rready); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++;
      $display("FAIL rst_resp_valid got=%b want=0", bus.resp_valid); end
    total++; if (bus.resp_error !== 1'b0) begin bad++;
      $display("FAIL rst_resp_error got=%b want=0", bus.resp_error); end
    total++; if (bus.resp_data !== '0) begin bad++;
      $display("FAIL rst_resp_data got nonzero want=0"); end
    reset = 1'b0;
  endtask

  task automatic test_basic_fill();
    set_beats(0);
    run_fill(64'h8000_1234, 0, 0, 0, 0, -1);
    total++; if (o_accepted !== 1'b1) begin bad++;
      $display("FAIL basic_accept got=%b want=1", o_accepted); end
    total++; if (o_araddr !== 64'h8000_1200) begin bad++;
      $display("FAIL basic_araddr got=%h want=80001200", o_araddr); end
    total++; if (o_arlen !== 8'd15) begin bad++;
      $display("FAIL basic_arlen got=%0d want=15", o_arlen); end
    total++; if ({o_arsize, o_arburst, o_arlock} !== 6'b011_01_0)
    begin bad++; $display("FAIL basic_arattr got=%b want=011010",
      {o_arsize, o_arburst, o_arlock}); end
    total++; if ({o_arid, o_arcache, o_arprot} !== {13'd0, 7'b0011_000})
    begin bad++; $display("FAIL basic_arid_cache got=%h want=%h",
      {o_arid, o_arcache, o_arprot}, {13'd0, 7'b0011_000}); end
    total++; if (o_latency !== 17) begin bad++;
      $display("FAIL basic_latency got=%0d want=17", o_latency); end
    total++; if (o_data !== model_line()) begin bad++;
      $display("FAIL basic_data got=%h want=%h", o_data[255:0],
        model_line() >> 0); end
    total++; if (o_err !== 1'b0) begin bad++;
      $display("FAIL basic_err got=%b want=0", o_err); end
    total++; if (o_rready_bad !== 0) begin bad++;
      $display("FAIL basic_rready got=%0d want=0", o_rready_bad); end
    total++; if (o_rdy_after !== 1'b1 || o_timeout !== 1'b0) begin bad++;
      $display("FAIL basic_done got=%b%b want=10",
        o_rdy_after, o_timeout); end
  endtask

  task automatic test_ar_stall();
    set_beats(1);
    run_fill({$urandom, $urandom}, 5, 0, 0, 0, -1);
    total++; if (o_ar_unstable !== 0) begin bad++;
      $display("FAIL stall_ar_stable got=%0d want=0", o_ar_unstable); end
    total++; if (o_ar_hs !== 1) begin bad++;
      $display("FAIL stall_ar_hs got=%0d want=1", o_ar_hs); end
    total++; if (o_latency !== 22) begin bad++;
      $display("FAIL stall_latency got=%0d want=22", o_latency); end
    total++; if (o_data !== model_line() || o_err !== 1'b0) begin bad++;
      $display("FAIL stall_resp got_err=%b want_err=0", o_err); end
  endtask

  task automatic test_rresp_error();
    set_beats(1);
    tb_resp[7] = 2'b10;
    run_fill({$urandom, $urandom}, 0, 0, 0, 0, -1);
    total++; if (o_data !== model_line()) begin bad++;
      $display("FAIL rresp_data got=%h want=%h",
        o_data[DW*8 +: DW], tb_data[8]); end
    total++; if (o_err !== 1'b1) begin bad++;
      $display("FAIL rresp_err got=%b want=1", o_err); end
  endtask

  task automatic test_early_rlast();
    set_beats(1);
    tb_last[3] = 1'b1;
    run_fill({$urandom, $urandom}, 0, 0, 0, 0, -1);
    total++; if (o_beats !== NB || o_latency !== 17) begin bad++;
      $display("FAIL rlast_beats got=%0d/%0d want=16/17",
        o_beats, o_latency); end
    total++; if (o_data !== model_line()) begin bad++;
      $display("FAIL rlast_data got=%h want=%h",
        o_data[DW*15 +: DW], tb_data[15]); end
    total++; if (o_err !== 1'b1) begin bad++;
      $display("FAIL rlast_err got=%b want=1", o_err); end
  endtask

  task automatic test_back_to_back();
    set_beats(1);
    run_fill({$urandom, $urandom}, 0, 0, 10, 1, -1);
    total++; if (o_resp_unstable !== 0) begin bad++;
      $display("FAIL bp_stable got=%0d want=0", o_resp_unstable); end
    total++; if (o_reqrdy_bad !== 0) begin bad++;
      $display("FAIL bp_req_ready got=%0d want=0", o_reqrdy_bad); end
    total++; if (o_rdy_after !== 1'b1 || o_arv_after !== 1'b0) begin bad++;
      $display("FAIL bp_reentry got=%b%b want=10",
        o_rdy_after, o_arv_after); end
    total++; if (o_resp_seen !== 11) begin bad++;
      $display("FAIL bp_resp_cycles got=%0d want=11", o_resp_seen); end
    total++; if (o_data !== model_line() || o_err !== 1'b0) begin bad++;
      $display("FAIL bp_resp got_err=%b want_err=0", o_err); end
  endtask

  task automatic test_reset_midfill();
    logic [AW-1:0] a;
    set_beats(1);
    tb_resp[2] = 2'b11;
    run_fill({$urandom, $urandom}, 0, 0, 0, 0, 9);
    @(negedge clk);
    total++; if (o_resp_seen !== 0) begin bad++;
      $display("FAIL mid_no_resp got=%0d want=0", o_resp_seen); end
    total++; if ({bus.req_ready, bus.m_axi_arvalid, bus.m_axi_rready,
                  bus.resp_valid, bus.resp_error} !== 5'b10000)
    begin bad++; $display("FAIL mid_outputs got=%b want=10000",
      {bus.req_ready, bus.m_axi_arvalid, bus.m_axi_rready,
       bus.resp_valid, bus.resp_error}); end
    total++; if (bus.resp_data !== '0) begin bad++;
      $display("FAIL mid_resp_data got nonzero want=0"); end
    reset = 1'b0;
    idle_inputs();
    set_beats(1);
    a = {$urandom, $urandom};
    run_fill(a, 0, 0, 0, 0, -1);
    total++; if (o_err !== 1'b0 || o_latency !== 17) begin bad++;
      $display("FAIL mid_refill got=%b/%0d want=0/17",
        o_err, o_latency); end
    total++; if (o_data !== model_line()) begin bad++;
      $display("FAIL mid_refill_data mismatch in line"); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    int aw, rw;
    for (int n = 0; n < 10; n++) begin
      set_beats(1);
      if ($urandom_range(0, 2) == 0)
        tb_resp[$urandom_range(0, NB-1)] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0)
        tb_last[$urandom_range(0, NB-1)] ^= 1'b1;
      a  = {$urandom, $urandom};
      aw = $urandom_range(0, 3);
      rw = $urandom_range(0, 3);
      run_fill(a, aw, 1, rw, 0, -1);
      total++; if (o_araddr !== (a & ~64'h7f)) begin bad++;
        $display("FAIL rnd%0d_araddr got=%h want=%h",
          n, o_araddr, a & ~64'h7f); end
      total++; if (o_latency !== 17 + aw + o_gaps) begin bad++;
        $display("FAIL rnd%0d_latency got=%0d want=%0d",
          n, o_latency, 17 + aw + o_gaps); end
      total++; if (o_data !== model_line()) begin bad++;
        $display("FAIL rnd%0d_data mismatch in line", n); end
      total++; if (o_err !== model_err()) begin bad++;
        $display("FAIL rnd%0d_err got=%b want=%b",
          n, o_err, model_err()); end
      total++; if (o_timeout !== 1'b0 || o_rready_bad !== 0) begin bad++;
        $display("FAIL rnd%0d_proto got=%b/%0d want=0/0",
          n, o_timeout, o_rready_bad); end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_basic_fill();
    test_ar_stall();
    test_rresp_error();
    test_early_rlast();
    test_back_to_back();
    test_reset_midfill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_fill_engine.md
LINE_FILL_ENGINE -- requirements
Module: line_fill_engine

Interface
REQ-001 Parameter ID_WIDTH, default 13, AXI ID width.
REQ-002 Parameter ADDR_WIDTH, default 64, address width.
REQ-003 Parameter DATA_WIDTH, default 64, AXI beat width.
REQ-004 Parameter BEATS, default 16, beats per cache line; line width LINE_W = DATA_WIDTH*BEATS (1024).
REQ-005 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 req_valid  in  1  cache requests a line fill.
REQ-009 req_ready  out  1  engine accepts a request.
REQ-010 req_addr  in  ADDR_WIDTH  miss address, any byte alignment.
REQ-011 resp_valid  out  1  filled line is available.
REQ-012 resp_ready  in  1  cache consumes the line.
REQ-013 resp_data  out  LINE_W  line data; beat k occupies bits [64k+63:64k].
REQ-014 resp_error  out  1  fill had a bus error or protocol fault.
REQ-015 m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/1  AXI read address channel.
REQ-016 m_axi_arready  in  1  AXI address accept.
REQ-017 m_axi_rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/DATA_WIDTH/2/1/1  AXI read data channel.
REQ-018 m_axi_rready  out  1  AXI data accept.

Function
REQ-019 States SHALL be IDLE, ADDR, DATA, RESP; one-hot or binary encoding is permitted.
REQ-020 IDLE: req_ready=1; on req_valid, latch the line-aligned address {req_addr[63:7],7'b0}, clear the beat counter and error flag, and go to ADDR.
REQ-021 ADDR: arvalid=1 with araddr=latched address, arlen=BEATS-1 (15), arsize=3, arburst=2'b01 (INCR), arid=0, arlock=0, arcache=4'b0011, arprot=3'b000.
REQ-022 ADDR: all AR outputs SHALL hold stable until arvalid&&arready, then go to DATA.
REQ-023 DATA: rready=1; each rvalid&&rready beat SHALL be written into slot[beat counter], and the counter SHALL increment.
REQ-024 A beat with rresp!=2'b00 SHALL set the sticky error flag; its data is still stored.
REQ-025 rlast=1 on a beat other than index BEATS-1, or rlast=0 on beat BEATS-1, SHALL set the error flag.
REQ-026 Termination SHALL depend on beat count only: after beat BEATS-1 is accepted, go to RESP.
REQ-027 RESP: resp_valid=1 and resp_error=flag; resp_data and resp_error SHALL hold stable until resp_valid&&resp_ready, then go to IDLE.
REQ-028 Exactly one fill SHALL be outstanding at a time; req_ready=0 in every state except IDLE.
REQ-029 A request SHALL NOT be accepted in the cycle a response completes; IDLE must be re-entered first.
REQ-030 Minimum latency from request accept to resp_valid SHALL be 1 (ADDR) + BEATS (DATA) cycles = 17 cycles with arready and rvalid held high.
REQ-031 rready SHALL be 0 outside DATA; rvalid seen outside DATA SHALL be ignored.
REQ-032 rid SHALL NOT be checked.
REQ-033 The beat counter SHALL be log2(BEATS) bits wide and SHALL NOT wrap within a fill.
REQ-034 Beat slots not yet written SHALL retain their previous-fill contents; no zeroing is required.

Reset
REQ-035 On reset: state=IDLE, req_ready=1 on the following cycle, arvalid=0, rready=0, resp_valid=0, resp_error=0, beat counter=0, resp_data=0.
REQ-036 Reset asserted mid-fill (ADDR, DATA or RESP) SHALL abandon the fill with no response issued, and SHALL return to the REQ-035 values on the next edge.

Verification
REQ-037 Request 0x8000_1234 with arready=1 and a 16-beat rdata=k, rlast on beat 15 -> araddr=0x8000_1200, arlen=15, resp_data beat k = k, resp_error=0, resp_valid in cycle 17.
REQ-038 arready held 0 for 5 cycles -> araddr and arlen stable throughout, one handshake only, fill completes normally.
REQ-039 rresp=2'b10 on beat 7 only -> all 16 beats stored, resp_error=1.
REQ-040 rlast asserted on beat 3 -> engine still collects 16 beats, resp_error=1.
REQ-041 resp_ready held 0 for 10 cycles with req_valid high -> resp_data stable, req_ready=0 until one cycle after the response handshake.
REQ-042 reset pulsed during beat 9 -> all outputs at reset values, and the next request produces a clean fill with resp_error=0.
